// File: rtl/pc_seq_ctrl_pkg.sv
// Shared types and constants for the next-PC sequencer: FSM state encoding,
// npc source select codes and the default fetch/exception vectors.
package pc_seq_ctrl_pkg;

   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
   localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      REDIR = 2'd1,
      HALT  = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      SEL_PC4,
      SEL_BR,
      SEL_J,
      SEL_JR,
      SEL_EXC,
      SEL_EPC,
      SEL_HOLD
   } sel_t;

endpackage

// File: rtl/pc_seq_ctrl_npc_calc.sv
// Combinational target arithmetic and next-PC source mux. All sums wrap
// modulo 2^32; the select code alone decides which candidate reaches npc.
module pc_seq_ctrl_npc_calc
   import pc_seq_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VEC = DEF_EXC_VEC
) (
   input  logic [31:0] pc,
   input  logic [15:0] br_imm,
   input  logic [25:0] j_idx,
   input  logic [31:0] jr_target,
   input  logic [31:0] epc,
   input  sel_t        sel,
   output logic [31:0] npc
);

   logic [31:0] pc4;
   logic [31:0] br_target;
   logic [31:0] j_target;

   assign pc4       = pc + 32'd4;
   // Word offset, sign-extended, then scaled to bytes.
   assign br_target = pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
   // Jump stays within the 256 MB region of the delay-slot address.
   assign j_target  = {pc4[31:28], j_idx, 2'b00};

   // Source mux driven by the controller's select code.
   always_comb begin
      unique case (sel)
         SEL_PC4:  npc = pc4;
         SEL_BR:   npc = br_target;
         SEL_J:    npc = j_target;
         SEL_JR:   npc = jr_target;
         SEL_EXC:  npc = EXC_VEC;
         SEL_EPC:  npc = epc;
         SEL_HOLD: npc = pc;
         default:  npc = pc;
      endcase
   end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer: chooses the fetch source each cycle, drives the PC
// register load enable and fetch flush, and owns the EPC/EXL exception state.
module pc_seq_ctrl
   import pc_seq_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
   parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [15:0] br_imm,
   input  logic        j_req,
   input  logic [25:0] j_idx,
   input  logic        jr_req,
   input  logic [31:0] jr_target,
   input  logic        exc_req,
   input  logic        eret,
   input  logic        halt_req,
   output logic [31:0] npc,
   output logic        pc_we,
   output logic        flush,
   output logic [31:0] epc,
   output logic        exl,
   output logic        halted
);

   state_t      state;
   state_t      state_nxt;
   sel_t        sel;
   logic        we_c;
   logic        flush_c;
   logic        take_exc;
   logic        take_eret;
   logic [31:0] npc_calc;

   pc_seq_ctrl_npc_calc #(
      .EXC_VEC (EXC_VEC)
   ) u_npc_calc (
      .pc        (pc),
      .br_imm    (br_imm),
      .j_idx     (j_idx),
      .jr_target (jr_target),
      .epc       (epc),
      .sel       (sel),
      .npc       (npc_calc)
   );

   // Decode requests into a source select, enables and the next FSM state.
   // NOTE: every output gets a default first so no path leaves a latch.
   always_comb begin
      sel       = SEL_PC4;
      we_c      = 1'b1;
      flush_c   = 1'b0;
      state_nxt = state;
      take_exc  = 1'b0;
      take_eret = 1'b0;
      unique case (state)
         RUN: begin
            if (exc_req && !exl) begin
               sel       = SEL_EXC;
               flush_c   = 1'b1;
               take_exc  = 1'b1;
               state_nxt = REDIR;
            end else if (stall) begin
               sel  = SEL_HOLD;
               we_c = 1'b0;
            end else if (eret) begin
               sel       = SEL_EPC;
               flush_c   = 1'b1;
               take_eret = 1'b1;
               state_nxt = REDIR;
            end else if (jr_req) begin
               sel       = SEL_JR;
               flush_c   = 1'b1;
               state_nxt = REDIR;
            end else if (j_req) begin
               sel       = SEL_J;
               flush_c   = 1'b1;
               state_nxt = REDIR;
            end else if (br_taken) begin
               sel       = SEL_BR;
               flush_c   = 1'b1;
               state_nxt = REDIR;
            end else if (halt_req) begin
               sel       = SEL_HOLD;
               we_c      = 1'b0;
               state_nxt = HALT;
            end
         end
         REDIR: begin
            // Bubble cycle: wrong-path control flow is dropped, exceptions are not.
            flush_c = 1'b1;
            if (exc_req && !exl) begin
               sel       = SEL_EXC;
               take_exc  = 1'b1;
               state_nxt = REDIR;
            end else begin
               state_nxt = RUN;
            end
         end
         HALT: begin
            sel  = SEL_HOLD;
            we_c = 1'b0;
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   // While reset is held the PC register sees the reset vector and no load.
   assign npc   = rst_n ? npc_calc : RESET_VEC;
   assign pc_we = rst_n & we_c;
   assign flush = rst_n & flush_c;

   // FSM state plus exception and halt registers, synchronous reset.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= RUN;
         epc    <= 32'h0;
         exl    <= 1'b0;
         halted <= 1'b0;
      end else begin
         state  <= state_nxt;
         halted <= (state_nxt == HALT);
         if (take_exc) begin
            epc <= pc;
            exl <= 1'b1;
         end else if (take_eret) begin
            exl <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_pc_seq_ctrl;

   localparam logic [31:0] RST_ADDR = 32'h0000_3000;
   localparam logic [31:0] VEC_ADDR = 32'h0000_4180;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc;
   logic        stall;
   logic        br_taken;
   logic [15:0] br_imm;
   logic        j_req;
   logic [25:0] j_idx;
   logic        jr_req;
   logic [31:0] jr_target;
   logic        exc_req;
   logic        eret;
   logic        halt_req;
   logic [31:0] npc;
   logic        pc_we;
   logic        flush;
   logic [31:0] epc;
   logic        exl;
   logic        halted;

   pc_seq_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pc        (pc),
      .stall     (stall),
      .br_taken  (br_taken),
      .br_imm    (br_imm),
      .j_req     (j_req),
      .j_idx     (j_idx),
      .jr_req    (jr_req),
      .jr_target (jr_target),
      .exc_req   (exc_req),
      .eret      (eret),
      .halt_req  (halt_req),
      .npc       (npc),
      .pc_we     (pc_we),
      .flush     (flush),
      .epc       (epc),
      .exl       (exl),
      .halted    (halted)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: mode 0 = sequential, 1 = bubble after redirect, 2 = stopped.
   int          m_mode   = 0;
   logic [31:0] m_epc    = 32'h0;
   bit          m_exl    = 1'b0;
   bit          m_halted = 1'b0;
   bit          m_known  = 1'b0;

   // Expectations for the current cycle.
   logic [31:0] e_npc;
   bit          e_we;
   bit          e_flush;
   int          e_mode;
   bit          e_save;
   bit          e_clear;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // What the outputs must be this cycle, from the sequencing rules.
   task automatic predict();
      logic [31:0] seq;
      logic [31:0] off;
      bit          exc_live;
      seq      = pc + 32'd4;
      off      = {{16{br_imm[15]}}, br_imm} * 32'd4;
      exc_live = exc_req && !m_exl;
      e_mode   = m_mode;
      e_save   = 1'b0;
      e_clear  = 1'b0;
      e_we     = 1'b1;
      e_flush  = 1'b0;
      if (!rst_n) begin
         e_npc = RST_ADDR; e_we = 1'b0;
      end else if (m_mode == 2) begin
         e_npc = pc; e_we = 1'b0;
      end else if (exc_live) begin
         e_npc = VEC_ADDR; e_flush = 1'b1; e_mode = 1; e_save = 1'b1;
      end else if (m_mode == 1) begin
         e_npc = seq; e_flush = 1'b1; e_mode = 0;
      end else if (stall) begin
         e_npc = pc; e_we = 1'b0;
      end else if (eret) begin
         e_npc = m_epc; e_flush = 1'b1; e_mode = 1; e_clear = 1'b1;
      end else if (jr_req) begin
         e_npc = jr_target; e_flush = 1'b1; e_mode = 1;
      end else if (j_req) begin
         e_npc = (seq & 32'hF000_0000) | ({6'd0, j_idx} * 32'd4); e_flush = 1'b1; e_mode = 1;
      end else if (br_taken) begin
         e_npc = seq + off; e_flush = 1'b1; e_mode = 1;
      end else if (halt_req) begin
         e_npc = pc; e_we = 1'b0; e_mode = 2;
      end else begin
         e_npc = seq;
      end
   endtask

   // Compare point: falling edge, inputs stable, registers settled.
   task automatic settle();
      @(negedge clk);
      predict();
      check("npc", npc, e_npc);
      check("pc_we", {31'd0, pc_we}, {31'd0, e_we});
      check("flush", {31'd0, flush}, {31'd0, e_flush});
      if (m_known) begin
         check("epc", epc, m_epc);
         check("exl", {31'd0, exl}, {31'd0, m_exl});
         check("halted", {31'd0, halted}, {31'd0, m_halted});
      end
   endtask

   // Clock edge: advance the model, then give inputs a safe drive window.
   task automatic advance();
      @(posedge clk);
      if (!rst_n) begin
         m_mode = 0; m_epc = 32'h0; m_exl = 1'b0; m_halted = 1'b0; m_known = 1'b1;
      end else begin
         m_mode = e_mode;
         if (e_save) begin
            m_epc = pc; m_exl = 1'b1;
         end else if (e_clear) begin
            m_exl = 1'b0;
         end
         m_halted = (e_mode == 2);
      end
      #1;
   endtask

   task automatic clear_req();
      stall = 0; br_taken = 0; j_req = 0; jr_req = 0;
      exc_req = 0; eret = 0; halt_req = 0;
   endtask

   initial begin
      rst_n = 0; pc = 32'h3000; br_imm = 16'h0; j_idx = 26'h0; jr_target = 32'h0;
      clear_req();

      // Reset held two cycles, then sequential fetch.
      repeat (2) begin
         settle();
         check("rst_npc", npc, 32'h0000_3000);
         check("rst_we", {31'd0, pc_we}, 32'd0);
         advance();
      end
      rst_n = 1;
      settle();
      check("seq_npc", npc, 32'h0000_3004);
      check("seq_we", {31'd0, pc_we}, 32'd1);
      check("seq_flush", {31'd0, flush}, 32'd0);
      check("rst_exl", {31'd0, exl}, 32'd0);
      advance();

      // Backward branch, then the bubble cycle, then wrap-around.
      pc = 32'h3010; br_taken = 1; br_imm = 16'hFFFC;
      settle();
      check("br_npc", npc, 32'h0000_3004);
      check("br_flush", {31'd0, flush}, 32'd1);
      advance();
      clear_req(); pc = 32'h3004;
      settle();
      check("redir_flush", {31'd0, flush}, 32'd1);
      check("redir_npc", npc, 32'h0000_3008);
      advance();
      pc = 32'hFFFF_FFFC;
      settle();
      check("wrap_npc", npc, 32'h0000_0000);
      check("wrap_flush", {31'd0, flush}, 32'd0);
      advance();

      // Jump beats branch; jump-register beats both.
      pc = 32'h3020; j_req = 1; j_idx = 26'h0000C40; br_taken = 1; br_imm = 16'h0010;
      settle();
      check("j_npc", npc, 32'h0000_3100);
      advance();
      clear_req(); settle(); advance();
      pc = 32'h3020; j_req = 1; br_taken = 1; jr_req = 1; jr_target = 32'h5000;
      settle();
      check("jr_npc", npc, 32'h0000_5000);
      advance();
      clear_req(); settle(); advance();

      // Exception beats stall; repeated request masked; eret returns.
      pc = 32'h3040; exc_req = 1; stall = 1;
      settle();
      check("exc_npc", npc, 32'h0000_4180);
      advance();
      stall = 0; pc = 32'h4180;
      settle();
      check("exc_epc", epc, 32'h0000_3040);
      check("exc_exl", {31'd0, exl}, 32'd1);
      check("masked_redir_npc", npc, 32'h0000_4184);
      advance();
      pc = 32'h4184;
      settle();
      check("masked_npc", npc, 32'h0000_4188);
      check("masked_flush", {31'd0, flush}, 32'd0);
      advance();
      exc_req = 0; eret = 1; pc = 32'h4188;
      settle();
      check("eret_npc", npc, 32'h0000_3040);
      advance();
      clear_req();
      settle();
      check("eret_exl", {31'd0, exl}, 32'd0);
      advance();

      // Stall holds PC and suppresses the branch.
      pc = 32'h3050; stall = 1; br_taken = 1;
      repeat (3) begin
         settle();
         check("stall_npc", npc, 32'h0000_3050);
         check("stall_we", {31'd0, pc_we}, 32'd0);
         check("stall_flush", {31'd0, flush}, 32'd0);
         advance();
      end
      clear_req();

      // Halt is sticky until reset.
      pc = 32'h3060; halt_req = 1;
      settle();
      check("halt_we", {31'd0, pc_we}, 32'd0);
      advance();
      halt_req = 0;
      repeat (5) begin
         settle();
         check("halted", {31'd0, halted}, 32'd1);
         check("halted_we", {31'd0, pc_we}, 32'd0);
         advance();
      end

      // Reset out of halt, enter REDIR via exception, reset mid-REDIR.
      rst_n = 0; settle(); advance();
      rst_n = 1; pc = 32'h3070; exc_req = 1;
      settle(); advance();
      exc_req = 0; rst_n = 0;
      settle();
      check("rst_redir_flush", {31'd0, flush}, 32'd0);
      advance();
      rst_n = 1; pc = 32'h3000;
      settle();
      check("post_rst_flush", {31'd0, flush}, 32'd0);
      check("post_rst_halted", {31'd0, halted}, 32'd0);
      check("post_rst_exl", {31'd0, exl}, 32'd0);
      advance();

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rst_n     = ($urandom_range(0, 49) != 0);
         pc        = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & 32'hFFFF_FFFC);
         stall     = ($urandom_range(0, 5) == 0);
         br_taken  = ($urandom_range(0, 4) == 0);
         br_imm    = 16'($urandom);
         j_req     = ($urandom_range(0, 6) == 0);
         j_idx     = 26'($urandom);
         jr_req    = ($urandom_range(0, 7) == 0);
         jr_target = $urandom;
         exc_req   = ($urandom_range(0, 9) == 0);
         eret      = ($urandom_range(0, 9) == 0);
         halt_req  = ($urandom_range(0, 59) == 0);
         settle();
         advance();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Next-PC sequencer and controller for the single-issue MIPS datapath.
- Each cycle it picks the next fetch address from six sources: sequential, branch, jump, jump-register, exception vector and exception return.
- It drives npc and a write enable into the PC register, and owns the EPC/EXL exception state.
- A small FSM handles stalls, redirect flushes, exception entry and halt.

Parameters:
- RESET_VEC, 32'h0000_3000, fetch address after reset; npc value while in reset.
- EXC_VEC, 32'h0000_4180, exception handler entry address.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- pc  in  32  current PC register value.
- stall  in  1  hazard stall; hold PC.
- br_taken  in  1  conditional branch resolved taken this cycle.
- br_imm  in  16  branch offset, in words.
- j_req  in  1  J/JAL this cycle.
- j_idx  in  26  jump instruction index.
- jr_req  in  1  JR/JALR this cycle.
- jr_target  in  32  register-sourced jump target.
- exc_req  in  1  synchronous exception/interrupt request.
- eret  in  1  exception return instruction.
- halt_req  in  1  BREAK/stop request.
- npc  out  32  next PC to the PC register.
- pc_we  out  1  PC register load enable.
- flush  out  1  squash the wrong-path instruction in fetch.
- epc  out  32  saved exception PC.
- exl  out  1  exception level (handler active).
- halted  out  1  core stopped.

Behaviour:
- All state updates on posedge clk; reset is sampled only at a clock edge.
- Reset (rst_n=0) values: state=RUN, epc=0, exl=0, halted=0, flush=0, pc_we=0, npc=RESET_VEC.
- First cycle after reset release: pc_we=1 with normal npc selection.
- Address arithmetic, all modulo 2^32 with wrap-around:
  - pc4 = pc+4.
  - Branch target = pc4 + (sign-extended br_imm << 2).
  - Jump target = {pc4[31:28], j_idx, 2'b00}.
  - jr_target is used unaltered; no alignment check.
- npc is combinational; select priority: exc_req (if !exl) > eret > jr_req > j_req > br_taken > pc4.
- FSM states: RUN, REDIR, HALT.
- RUN:
  - stall=1 and no exception: pc_we=0, npc=pc, no state change. Stall overrides control-flow requests; the datapath re-presents them.
  - exc_req and !exl: npc=EXC_VEC, pc_we=1, epc<=pc, exl<=1, flush=1. Exception wins over stall. Go to REDIR.
  - exc_req while exl=1: ignored (masked).
  - eret: npc=epc, pc_we=1, exl<=0, flush=1; go to REDIR. eret with exl=0 still redirects to epc.
  - jr_req, j_req or br_taken: pc_we=1, flush=1; go to REDIR.
  - No request: sequential fetch, pc_we=1, flush=0.
  - halt_req (lowest priority, sampled only in RUN without stall): pc_we=0; go to HALT.
- REDIR:
  - Exactly one cycle; flush=1 is registered and covers the bubble cycle.
  - Control-flow requests this cycle are ignored (wrong path). Exceptions are still honoured per the RUN rules.
  - pc_we=1, npc=pc4; return to RUN.
- HALT: pc_we=0, npc=pc, halted=1; exits only via reset.
- Reset asserted in any state returns to RUN with the reset values above, abandoning an in-progress REDIR.
- Simultaneous requests: the highest-priority source alone sets npc. Multiple lower requests are not errors.

Decomposition:
- Shared package holds:
  - State encoding: RUN=2'd0, REDIR=2'd1, HALT=2'd2.
  - RESET_VEC/EXC_VEC defaults.
  - npc-source select encoding: SEL_PC4, SEL_BR, SEL_J, SEL_JR, SEL_EXC, SEL_EPC, SEL_HOLD.
- One natural sub-module, npc_calc: purely combinational target computation and source mux. The FSM and EPC/EXL registers stay in pc_seq_ctrl.

Test Plan:
- Reset then sequential run: hold rst_n=0 two cycles, release with pc=32'h3000 -> npc=32'h3000 while in reset; then npc=32'h3004, pc_we=1, flush=0.
- Backward branch at wrap: pc=32'h3010, br_taken=1, br_imm=16'hFFFC -> npc=32'h3004, flush=1 for two cycles, REDIR then RUN. pc=32'hFFFF_FFFC, no request -> npc=32'h0.
- Jump priority over branch: pc=32'h3020, j_req=1, j_idx=26'h0000C40, br_taken=1 -> npc=32'h3100; with jr_req=1 and jr_target=32'h5000 also asserted -> npc=32'h5000.
- Exception and return:
  - pc=32'h3040, exc_req=1, stall=1 -> npc=32'h4180, epc=32'h3040, exl=1.
  - Second exc_req while exl=1 -> ignored.
  - eret -> npc=32'h3040, exl=0.
- Stall hold: stall=1 for 3 cycles with br_taken=1 -> pc_we=0, npc=pc throughout, no flush.
- Halt and mid-operation reset:
  - halt_req in RUN -> halted=1, pc_we=0 held for 5 cycles.
  - rst_n=0 asserted during REDIR -> next cycle state RUN, flush=0, halted=0, exl=0.
